// File: rtl/ucsbece154b_victim_pkg.sv
// Shared types and constants for the victim-cache miss controller.
package ucsbece154b_victim_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4
    } victim_ctrl_state_e;

    localparam logic FILL_SRC_VC  = 1'b1;
    localparam logic FILL_SRC_MEM = 1'b0;

    // Number of byte-offset bits inside one cache line.
    function automatic int unsigned line_offset_width(input int unsigned line_width);
        return $clog2(line_width / 32'd8);
    endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module ucsbece154b_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment only while below the saturation value
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ucsbece154b_victim_ctrl.sv
// Sequences one L1 miss at a time through the victim cache and, on a victim
// miss, through the next memory level; also serializes victim-cache flushes.
module ucsbece154b_victim_ctrl
    import ucsbece154b_victim_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  fill_valid_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  fill_src_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    input  logic                  vc_hit_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    localparam int unsigned OFF_W = line_offset_width(LINE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    victim_ctrl_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ev_valid_q, ev_valid_d;
    logic [ADDR_WIDTH-1:0] ev_addr_q, ev_addr_d;
    logic [LINE_WIDTH-1:0] ev_data_q, ev_data_d;
    logic [LINE_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  fill_src_q, fill_src_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  en_q;

    logic miss_ready_s, vc_flush_s, vc_we_s, req_valid_s, fill_valid_s;
    logic hit_inc_s, miss_inc_s;

    // Next-state, latch updates and per-state output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ev_valid_d   = ev_valid_q;
        ev_addr_d    = ev_addr_q;
        ev_data_d    = ev_data_q;
        fill_data_d  = fill_data_q;
        fill_src_d   = fill_src_q;
        miss_ready_s = 1'b0;
        vc_flush_s   = 1'b0;
        vc_we_s      = 1'b0;
        req_valid_s  = 1'b0;
        fill_valid_s = 1'b0;
        hit_inc_s    = 1'b0;
        miss_inc_s   = 1'b0;

        // Flushes seen mid-miss are remembered and replayed once back in IDLE.
        if (flush_i && (state_q != IDLE)) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end

        case (state_q)
            IDLE: begin
                if (!en_q) begin
                    flush_pend_d = flush_pend_q | flush_i;
                end else if (flush_i || flush_pend_q) begin
                    vc_flush_s   = 1'b1;
                    flush_pend_d = 1'b0;
                end else begin
                    miss_ready_s = 1'b1;
                    if (miss_valid_i) begin
                        addr_d     = miss_addr_i;
                        ev_valid_d = evict_valid_i;
                        ev_addr_d  = evict_addr_i;
                        ev_data_d  = evict_data_i;
                        state_d    = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOOKUP: begin
                vc_we_s = ev_valid_q;
                if (vc_hit_i) begin
                    fill_data_d = vc_rdata_i;
                    fill_src_d  = FILL_SRC_VC;
                    hit_inc_s   = 1'b1;
                    state_d     = FILL;
                end else begin
                    miss_inc_s = 1'b1;
                    state_d    = MEM_REQ;
                end
            end
            MEM_REQ: begin
                req_valid_s = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (mem_rsp_valid_i) begin
                    fill_data_d = mem_rsp_data_i;
                    fill_src_d  = FILL_SRC_MEM;
                    state_d     = FILL;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            FILL: begin
                fill_valid_s = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transaction latches, fill buffer and flush bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            ev_valid_q   <= 1'b0;
            ev_addr_q    <= '0;
            ev_data_q    <= '0;
            fill_data_q  <= '0;
            fill_src_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ev_valid_q   <= ev_valid_d;
            ev_addr_q    <= ev_addr_d;
            ev_data_q    <= ev_data_d;
            fill_data_q  <= fill_data_d;
            fill_src_q   <= fill_src_d;
            flush_pend_q <= flush_pend_d;
            en_q         <= 1'b1;
        end
    end

    ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (hit_inc_s),
        .count_o (hit_count_o)
    );

    ucsbece154b_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (miss_inc_s),
        .count_o (miss_count_o)
    );

    assign miss_ready_o    = miss_ready_s;
    assign fill_valid_o    = fill_valid_s;
    assign fill_data_o     = fill_data_q;
    assign fill_src_o      = fill_src_q;
    assign mem_req_valid_o = req_valid_s;
    assign mem_req_addr_o  = addr_q & LINE_MASK;
    assign vc_en_o         = en_q;
    assign vc_flush_o      = vc_flush_s;
    assign vc_we_o         = vc_we_s;
    assign vc_raddr_o      = addr_q;
    assign vc_waddr_o      = ev_addr_q;
    assign vc_wdata_o      = ev_data_q;

endmodule

// File: tb/tb_ucsbece154b_victim_ctrl.sv
// Self-checking bench: behavioural victim cache + memory around the controller,
// with an associative-array reference model of expected fills and counters.
module tb_ucsbece154b_victim_ctrl;

    localparam int AW   = 56;
    localparam int LW   = 128;
    localparam int CW   = 2;
    localparam int VC_N = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [AW-1:0] miss_addr = '0;
    logic          evict_valid = 1'b0;
    logic [AW-1:0] evict_addr = '0;
    logic [LW-1:0] evict_data = '0;
    logic          fill_valid;
    logic [LW-1:0] fill_data;
    logic          fill_src;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [LW-1:0] mem_rsp_data = '0;
    logic          vc_en, vc_flush, vc_we;
    logic [AW-1:0] vc_raddr, vc_waddr;
    logic [LW-1:0] vc_wdata;
    logic [LW-1:0] vc_rdata;
    logic          vc_hit;
    logic [CW-1:0] hit_count, miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ucsbece154b_victim_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_addr_i(miss_addr),
        .evict_valid_i(evict_valid), .evict_addr_i(evict_addr), .evict_data_i(evict_data),
        .fill_valid_o(fill_valid), .fill_data_o(fill_data), .fill_src_o(fill_src),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i(mem_rsp_data), .vc_en_o(vc_en), .vc_flush_o(vc_flush),
        .vc_we_o(vc_we), .vc_raddr_o(vc_raddr), .vc_waddr_o(vc_waddr),
        .vc_wdata_o(vc_wdata), .vc_rdata_i(vc_rdata), .vc_hit_i(vc_hit),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    function automatic logic [AW-1:0] aligned(input logic [AW-1:0] a);
        return {a[AW-1:4], 4'h0};
    endfunction

    // ---------------- behavioural victim cache (environment) ----------------
    logic [AW-1:0] vc_tag [VC_N];
    logic [LW-1:0] vc_dat [VC_N];
    bit            vc_val [VC_N];
    int            wr_slot;

    always_comb begin
        vc_hit   = 1'b0;
        vc_rdata = '0;
        for (int i = 0; i < VC_N; i++) begin
            if (vc_en && vc_val[i] && vc_tag[i] == aligned(vc_raddr)) begin
                vc_hit   = 1'b1;
                vc_rdata = vc_dat[i];
            end
        end
    end

    always_comb begin
        wr_slot = -1;
        for (int i = 0; i < VC_N; i++)
            if (vc_val[i] && vc_tag[i] == aligned(vc_waddr)) wr_slot = i;
        for (int i = 0; i < VC_N; i++)
            if (!vc_val[i] && wr_slot < 0) wr_slot = i;
    end

    always @(posedge clk) begin
        if (!vc_en || vc_flush) begin
            for (int i = 0; i < VC_N; i++) vc_val[i] <= 1'b0;
        end else if (vc_we && wr_slot >= 0) begin
            vc_val[wr_slot] <= 1'b1;
            vc_tag[wr_slot] <= aligned(vc_waddr);
            vc_dat[wr_slot] <= vc_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [LW-1:0] ref_vc [logic [AW-1:0]];
    int ref_hits, ref_misses;

    task automatic model_clear_all();
        ref_vc.delete();
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic model_miss(input logic [AW-1:0] a, input logic ev_v, input logic [AW-1:0] ev_a,
                              input logic [LW-1:0] ev_d, input logic [LW-1:0] mem_d,
                              output logic [LW-1:0] exp_d, output logic exp_src);
        if (ref_vc.exists(aligned(a))) begin
            exp_d = ref_vc[aligned(a)];
            exp_src = 1'b1;
            if (ref_hits < CMAX) ref_hits++;
        end else begin
            exp_d = mem_d;
            exp_src = 1'b0;
            if (ref_misses < CMAX) ref_misses++;
        end
        if (ev_v) ref_vc[aligned(ev_a)] = ev_d;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- transaction driver (collects observations) ----------------
    typedef struct packed {
        logic          timeout;
        logic          got_fill;
        logic          fsrc;
        logic          req_stable;
        logic          we;
        logic [LW-1:0] fdata;
        logic [LW-1:0] wdata;
        logic [AW-1:0] req_addr;
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        int            fill_k;
        int            req_k;
        int            hs_k;
        int            n_hs;
        int            n_req;
    } obs_t;

    task automatic run_miss(input logic [AW-1:0] a, input logic ev_v, input logic [AW-1:0] ev_a,
                            input logic [LW-1:0] ev_d, input logic [LW-1:0] mem_d,
                            input int ready_lat, input int rsp_lat, input logic flush_in_wait,
                            output obs_t o);
        int wait_n;
        o = '0;
        o.req_stable = 1'b1;
        o.fill_k = -1; o.req_k = -1; o.hs_k = -1;
        wait_n = 0;
        do begin
            @(negedge clk);
            miss_valid = 1'b1; miss_addr = a;
            evict_valid = ev_v; evict_addr = ev_a; evict_data = ev_d;
            #1 wait_n++;
        end while (!miss_ready && wait_n < 50);
        if (!miss_ready) begin
            o.timeout = 1'b1;
            miss_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            miss_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
            if (flush_in_wait && o.hs_k >= 0 && k == o.hs_k + 1) flush = 1'b1;
            #1;
            if (k == 1) begin
                o.we = vc_we; o.waddr = vc_waddr; o.wdata = vc_wdata; o.raddr = vc_raddr;
            end
            if (fill_valid) begin
                o.got_fill = 1'b1; o.fdata = fill_data; o.fsrc = fill_src; o.fill_k = k;
                break;
            end
            if (mem_req_valid) begin
                if (o.n_req == 0) begin
                    o.req_addr = mem_req_addr; o.req_k = k;
                end else if (mem_req_addr !== o.req_addr) begin
                    o.req_stable = 1'b0;
                end
                o.n_req++;
                // A stray response strobe while the request is pending must be ignored.
                mem_rsp_valid = 1'b1; mem_rsp_data = ~mem_d;
                if (o.n_req > ready_lat) begin
                    mem_req_ready = 1'b1; o.n_hs++; o.hs_k = k;
                end
            end else if (o.hs_k >= 0 && k == o.hs_k + 1 + rsp_lat) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = mem_d;
            end
        end
        if (!o.got_fill) o.timeout = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        miss_valid = 1'b0; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear_all();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ((|{miss_ready, fill_valid, fill_src, mem_req_valid, vc_en, vc_flush, vc_we,
               fill_data, mem_req_addr, vc_raddr, vc_waddr, vc_wdata, hit_count, miss_count}) !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero in reset (vc_en=%b miss_ready=%b)", vc_en, miss_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_all();
        #1;
        n_checks++;
        if (vc_en !== 1'b0) begin n_fail++; $display("FAIL reset_vc_en_release: got %b expected 0", vc_en); end
        @(negedge clk); #1;
        n_checks++;
        if (vc_en !== 1'b1) begin n_fail++; $display("FAIL reset_vc_en_after: got %b expected 1", vc_en); end
        n_checks++;
        if (miss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_miss_ready: got %b expected 1", miss_ready); end
        n_checks++;
        if ((|{fill_valid, mem_req_valid, vc_flush, vc_we, hit_count, miss_count}) !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_outputs: hit=%0d miss=%0d fv=%b mrv=%b", hit_count, miss_count, fill_valid, mem_req_valid);
        end
    endtask

    task automatic test_install_hit();
        obs_t o;
        logic [LW-1:0] a_line, b_line, exp_d;
        logic exp_src;
        a_line = rnd_line(); b_line = rnd_line();
        model_miss(56'h1040, 1'b1, 56'h2000, a_line, b_line, exp_d, exp_src);
        run_miss(56'h1040, 1'b1, 56'h2000, a_line, b_line, 0, 0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.fdata !== b_line || o.fsrc !== 1'b0) begin
            n_fail++; $display("FAIL install_mem_fill: got %h src %b expected %h src 0", o.fdata, o.fsrc, b_line);
        end
        n_checks++;
        if (o.req_addr !== 56'h1040 || o.req_k != 2 || o.fill_k != o.hs_k + 2) begin
            n_fail++; $display("FAIL install_mem_req: addr %h req_k %0d fill_k %0d hs_k %0d expected 1040/2/hs+2", o.req_addr, o.req_k, o.fill_k, o.hs_k);
        end
        n_checks++;
        if (o.we !== 1'b1 || o.waddr !== 56'h2000 || o.wdata !== a_line || o.raddr !== 56'h1040) begin
            n_fail++; $display("FAIL install_vc_write: we %b waddr %h raddr %h expected 1/2000/1040", o.we, o.waddr, o.raddr);
        end
        n_checks++;
        if (miss_count !== CW'(ref_misses) || hit_count !== CW'(ref_hits)) begin
            n_fail++; $display("FAIL install_counts: hit %0d miss %0d expected %0d %0d", hit_count, miss_count, ref_hits, ref_misses);
        end
        model_miss(56'h2000, 1'b0, '0, '0, rnd_line(), exp_d, exp_src);
        run_miss(56'h2000, 1'b0, '0, '0, ~a_line, 0, 0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.fdata !== a_line || o.fsrc !== 1'b1 || exp_src !== 1'b1) begin
            n_fail++; $display("FAIL hit_fill: got %h src %b expected %h src 1", o.fdata, o.fsrc, a_line);
        end
        n_checks++;
        if (o.fill_k != 2 || o.n_req != 0 || o.we !== 1'b0) begin
            n_fail++; $display("FAIL hit_timing: fill_k %0d n_req %0d we %b expected 2/0/0", o.fill_k, o.n_req, o.we);
        end
        n_checks++;
        if (hit_count !== CW'(1) || miss_count !== CW'(1)) begin
            n_fail++; $display("FAIL hit_counts: hit %0d miss %0d expected 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [LW-1:0] m, exp_d;
        logic exp_src;
        m = rnd_line();
        model_miss(56'h3458, 1'b0, '0, '0, m, exp_d, exp_src);
        run_miss(56'h3458, 1'b0, '0, '0, m, 5, 1, 1'b0, o);
        n_checks++;
        if (o.n_req != 6 || !o.req_stable || o.req_addr !== 56'h3450) begin
            n_fail++; $display("FAIL bp_req_stable: valid cycles %0d stable %b addr %h expected 6/1/3450", o.n_req, o.req_stable, o.req_addr);
        end
        n_checks++;
        if (o.n_hs != 1 || o.timeout || o.fdata !== exp_d || o.fsrc !== exp_src || o.fill_k != o.hs_k + 3) begin
            n_fail++; $display("FAIL bp_fill: hs %0d data %h src %b fill_k %0d expected 1/%h/%b/%0d", o.n_hs, o.fdata, o.fsrc, o.fill_k, exp_d, exp_src, o.hs_k + 3);
        end
        @(negedge clk); #1;
        n_checks++;
        if (fill_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_fill: fill_valid %b expected 0", fill_valid); end
    endtask

    task automatic test_flush_mid_miss();
        obs_t o;
        logic [LW-1:0] m, exp_d;
        logic exp_src;
        m = rnd_line();
        model_miss(56'h4000, 1'b0, '0, '0, m, exp_d, exp_src);
        run_miss(56'h4000, 1'b0, '0, '0, m, 0, 2, 1'b1, o);
        n_checks++;
        if (o.timeout || o.fdata !== m || o.fsrc !== 1'b0) begin
            n_fail++; $display("FAIL flush_fill_delivered: got %h src %b expected %h src 0", o.fdata, o.fsrc, m);
        end
        @(negedge clk); #1;
        n_checks++;
        if (vc_flush !== 1'b1 || miss_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_pulse: vc_flush %b miss_ready %b expected 1 0", vc_flush, miss_ready);
        end
        ref_vc.delete();
        @(negedge clk); #1;
        n_checks++;
        if (vc_flush !== 1'b0 || miss_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_one_cycle: vc_flush %b miss_ready %b expected 0 1", vc_flush, miss_ready);
        end
        m = rnd_line();
        model_miss(56'h2000, 1'b0, '0, '0, m, exp_d, exp_src);
        run_miss(56'h2000, 1'b0, '0, '0, m, 0, 0, 1'b0, o);
        n_checks++;
        if (o.timeout || o.fsrc !== 1'b0 || o.fdata !== m || o.n_hs != 1) begin
            n_fail++; $display("FAIL flush_cleared_lookup: src %b data %h hs %0d expected src 0 data %h hs 1", o.fsrc, o.fdata, o.n_hs, m);
        end
    endtask

    task automatic test_mid_reset();
        int fills;
        @(negedge clk);
        miss_valid = 1'b1; miss_addr = 56'h5008; evict_valid = 1'b1;
        evict_addr = 56'h6000; evict_data = rnd_line();
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_in_req: mem_req_valid %b expected 1", mem_req_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ((|{miss_ready, fill_valid, fill_src, mem_req_valid, vc_en, vc_flush, vc_we,
               fill_data, mem_req_addr, hit_count, miss_count}) !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: mrv %b en %b fv %b miss %0d expected all 0", mem_req_valid, vc_en, fill_valid, miss_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear_all();
        fills = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_rsp_valid = (i < 4); mem_rsp_data = rnd_line();
            #1;
            if (fill_valid || mem_req_valid) fills++;
        end
        mem_rsp_valid = 1'b0;
        n_checks++;
        if (fills != 0) begin n_fail++; $display("FAIL midrst_no_fill: active cycles %0d expected 0", fills); end
        n_checks++;
        if (miss_ready !== 1'b1 || hit_count !== '0 || miss_count !== '0) begin
            n_fail++; $display("FAIL midrst_idle: ready %b hit %0d miss %0d expected 1 0 0", miss_ready, hit_count, miss_count);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        logic [LW-1:0] x, exp_d;
        logic exp_src;
        apply_reset();
        x = rnd_line();
        model_miss(56'h7000, 1'b1, 56'h7100, x, rnd_line(), exp_d, exp_src);
        run_miss(56'h7000, 1'b1, 56'h7100, x, exp_d, 0, 0, 1'b0, o);
        for (int i = 1; i <= 4; i++) begin
            model_miss(56'h7100, 1'b0, '0, '0, '0, exp_d, exp_src);
            run_miss(56'h7100, 1'b0, '0, '0, '0, 0, 0, 1'b0, o);
            n_checks++;
            if (o.fsrc !== 1'b1 || o.fdata !== x) begin
                n_fail++; $display("FAIL sat_hit_%0d: src %b data %h expected 1 %h", i, o.fsrc, o.fdata, x);
            end
            n_checks++;
            if (hit_count !== CW'((i < 3) ? i : 3)) begin
                n_fail++; $display("FAIL sat_count_%0d: hit_count %0d expected %0d", i, hit_count, (i < 3) ? i : 3);
            end
        end
        n_checks++;
        if (miss_count !== CW'(1)) begin n_fail++; $display("FAIL sat_miss_count: got %0d expected 1", miss_count); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [AW-1:0] a, ev_a;
        logic [LW-1:0] ev_d, m, exp_d;
        logic ev_v, exp_src;
        int rl, pl;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            a    = 56'h1000 + AW'($urandom_range(0, 5) * 16) + AW'($urandom_range(0, 15));
            ev_a = 56'h1000 + AW'($urandom_range(0, 5) * 16) + AW'($urandom_range(0, 15));
            ev_v = 1'($urandom_range(0, 1));
            ev_d = rnd_line(); m = rnd_line();
            rl = $urandom_range(0, 3); pl = $urandom_range(0, 3);
            model_miss(a, ev_v, ev_a, ev_d, m, exp_d, exp_src);
            run_miss(a, ev_v, ev_a, ev_d, m, rl, pl, 1'b0, o);
            n_checks++;
            if (o.timeout || o.fdata !== exp_d || o.fsrc !== exp_src) begin
                n_fail++; $display("FAIL rnd_fill it=%0d: got %h src %b expected %h src %b", it, o.fdata, o.fsrc, exp_d, exp_src);
            end
            n_checks++;
            if (exp_src ? (o.fill_k != 2 || o.n_req != 0)
                        : (o.req_k != 2 || o.n_hs != 1 || o.fill_k != o.hs_k + 2 + pl || o.req_addr !== aligned(a))) begin
                n_fail++; $display("FAIL rnd_timing it=%0d: fill_k %0d req_k %0d hs %0d addr %h", it, o.fill_k, o.req_k, o.n_hs, o.req_addr);
            end
            n_checks++;
            if (o.we !== ev_v || (ev_v && (o.waddr !== ev_a || o.wdata !== ev_d))) begin
                n_fail++; $display("FAIL rnd_vc_write it=%0d: we %b waddr %h expected %b %h", it, o.we, o.waddr, ev_v, ev_a);
            end
            n_checks++;
            if (hit_count !== CW'(ref_hits) || miss_count !== CW'(ref_misses)) begin
                n_fail++; $display("FAIL rnd_counts it=%0d: hit %0d miss %0d expected %0d %0d", it, hit_count, miss_count, ref_hits, ref_misses);
            end
        end
    endtask

    initial begin
        test_reset();
        test_install_hit();
        test_backpressure();
        test_flush_mid_miss();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
